// File: rtl/bnn_fmap_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : bnn_fmap_seq_if
// Purpose  : Control, write-stream and replay-stream bundle for bnn_fmap_seq.
// Revision : 1.0
// ============================================================================
interface bnn_fmap_seq_if #(
    parameter int N_CH   = 3,
    parameter int PASS_W = 4
);
    logic              start;
    logic              abort;
    logic [PASS_W-1:0] passes;
    logic [N_CH-1:0]   wr_valid;
    logic [N_CH-1:0]   wr_bit;
    logic              rd_ready;
    logic              rd_valid;
    logic [N_CH-1:0]   rd_bits;
    logic              rd_maj;
    logic              rd_last;
    logic              busy;
    logic              done;
    logic              overflow;

    modport master (
        output start, abort, passes, wr_valid, wr_bit, rd_ready,
        input  rd_valid, rd_bits, rd_maj, rd_last, busy, done, overflow
    );

    modport slave (
        input  start, abort, passes, wr_valid, wr_bit, rd_ready,
        output rd_valid, rd_bits, rd_maj, rd_last, busy, done, overflow
    );
endinterface
`default_nettype wire

// File: rtl/bnn_fmap_seq.sv
`default_nettype none
// ============================================================================
// Module   : bnn_fmap_seq
// Purpose  : Multi-channel binary feature-map buffer; fills per-channel maps,
//            then replays them a programmable number of passes with majority.
// Revision : 1.0
// ============================================================================
module bnn_fmap_seq #(
    parameter int N_CH     = 3,
    parameter int FMAP_LEN = 676,
    parameter int PASS_W   = 4,
    parameter int PTR_W    = $clog2(FMAP_LEN + 1)
) (
    input  wire logic       clk,
    input  wire logic       rst,
    bnn_fmap_seq_if.slave   bus
);
    localparam int AW   = (FMAP_LEN > 1) ? $clog2(FMAP_LEN) : 1;
    localparam int PC_W = $clog2(N_CH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [PTR_W-1:0]  c_full     = PTR_W'(FMAP_LEN);
    localparam logic [PTR_W-1:0]  c_last     = PTR_W'(FMAP_LEN - 1);
    localparam logic [PTR_W-1:0]  c_ptr_one  = PTR_W'(1);
    localparam logic [PASS_W-1:0] c_pass_one = PASS_W'(1);
    localparam logic [PC_W:0]     c_n_ch     = (PC_W + 1)'(N_CH);

    logic [1:0]        state_q,    state_d;
    logic [PTR_W-1:0]  wr_ptr_q [N_CH];
    logic [PTR_W-1:0]  wr_ptr_d [N_CH];
    logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [PASS_W-1:0] passes_q,   passes_d;
    logic              overflow_q, overflow_d;

    logic [N_CH-1:0]   w_we;
    logic [N_CH-1:0]   w_rd_bits;
    logic [PC_W-1:0]   w_pop;
    logic              w_all_full;
    logic              w_xfer;
    logic              w_final;
    logic [PASS_W-1:0] w_eff_passes;

    // One bit-map per channel; storage is intentionally not reset.
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [FMAP_LEN-1:0] map_mem;
        always_ff @(posedge clk) begin
            if (w_we[c]) begin
                map_mem[wr_ptr_q[c][AW-1:0]] <= bus.wr_bit[c];
            end
        end
        assign w_rd_bits[c] = map_mem[rd_ptr_q[AW-1:0]];
    end

    always_comb begin
        w_all_full = 1'b1;
        for (int c = 0; c < N_CH; c++) begin
            if (wr_ptr_q[c] != c_full) begin
                w_all_full = 1'b0;
            end
        end
    end

    always_comb begin
        w_pop = '0;
        for (int c = 0; c < N_CH; c++) begin
            w_pop = w_pop + PC_W'(w_rd_bits[c]);
        end
    end

    assign w_xfer       = (state_q == S_DRAIN) && bus.rd_ready;
    assign w_eff_passes = (passes_q == '0) ? c_pass_one : passes_q;
    assign w_final      = (pass_cnt_q == (w_eff_passes - c_pass_one));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rd_ptr_q   <= '0;
            pass_cnt_q <= '0;
            passes_q   <= '0;
            overflow_q <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                wr_ptr_q[c] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            pass_cnt_q <= pass_cnt_d;
            passes_q   <= passes_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (bus.start) state_d = S_FILL;
                S_FILL:  if (w_all_full) state_d = S_DRAIN;
                S_DRAIN: if (w_xfer && (rd_ptr_q == c_last) && w_final) state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Pointer, pass and overflow bookkeeping; abort clears positions but keeps overflow.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        pass_cnt_d = pass_cnt_q;
        passes_d   = passes_q;
        overflow_d = overflow_q;
        wr_ptr_d   = wr_ptr_q;
        w_we       = '0;
        if (bus.abort) begin
            rd_ptr_d   = '0;
            pass_cnt_d = '0;
            for (int c = 0; c < N_CH; c++) wr_ptr_d[c] = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        passes_d   = bus.passes;
                        overflow_d = 1'b0;
                        rd_ptr_d   = '0;
                        pass_cnt_d = '0;
                        for (int c = 0; c < N_CH; c++) wr_ptr_d[c] = '0;
                    end
                end
                S_FILL: begin
                    for (int c = 0; c < N_CH; c++) begin
                        if (bus.wr_valid[c]) begin
                            if (wr_ptr_q[c] == c_full) begin
                                overflow_d = 1'b1;
                            end else begin
                                w_we[c]     = 1'b1;
                                wr_ptr_d[c] = wr_ptr_q[c] + c_ptr_one;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_xfer) begin
                        if (rd_ptr_q == c_last) begin
                            rd_ptr_d   = '0;
                            pass_cnt_d = pass_cnt_q + c_pass_one;
                        end else begin
                            rd_ptr_d = rd_ptr_q + c_ptr_one;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.rd_valid = (state_q == S_DRAIN);
        bus.rd_bits  = (state_q == S_DRAIN) ? w_rd_bits : '0;
        bus.rd_maj   = (state_q == S_DRAIN) && ({w_pop, 1'b0} > c_n_ch);
        bus.rd_last  = (state_q == S_DRAIN) && (rd_ptr_q == c_last);
        bus.busy     = (state_q != S_IDLE);
        bus.done     = (state_q == S_DONE);
        bus.overflow = overflow_q;
    end
endmodule
`default_nettype wire
